// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing core.
// Time is packed {m1,m0,s1,s0,c1,c0}, one BCD digit per nibble.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } sw_state_e;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [23:0] bcd_time_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;

  localparam int unsigned C0_OFF = 0;
  localparam int unsigned C1_OFF = 4;
  localparam int unsigned S0_OFF = 8;
  localparam int unsigned S1_OFF = 12;
  localparam int unsigned M0_OFF = 16;
  localparam int unsigned M1_OFF = 20;

  localparam bcd_time_t ZERO_TIME = 24'h000000;
  localparam bcd_time_t MAX_TIME  = 24'h595999;

  // Largest legal value of the digit at bit offset off (tens of s/min are 0..5).
  function automatic bcd_digit_t digit_limit(int unsigned off);
    case (off)
      C0_OFF, C1_OFF, S0_OFF, M0_OFF: return MAX_TIME[C0_OFF +: DIGIT_W];
      S1_OFF, M1_OFF:                 return MAX_TIME[S1_OFF +: DIGIT_W];
      default:                        return 4'd9;
    endcase
  endfunction

  function automatic bcd_time_t clamp_time(bcd_time_t t);
    bcd_time_t  r;
    bcd_digit_t d;
    bcd_digit_t lim;
    r = t;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d   = t[i*DIGIT_W +: DIGIT_W];
      lim = digit_limit(i * DIGIT_W);
      if (d > lim) r[i*DIGIT_W +: DIGIT_W] = lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_step.sv
// Combinational one-centisecond step of a packed BCD time, up or down.
// Decrementing 00:00.00 saturates at zero instead of borrowing out.
module bcd_time_step
  import stopwatch_pkg::*;
(
  input  logic [23:0] time_i,
  input  logic        down_i,
  output logic [23:0] time_o,
  output logic        wrap_o,
  output logic        in_zero_o,
  output logic        out_zero_o
);

  logic       carry;
  bcd_digit_t d;
  bcd_digit_t lim;

  always_comb begin
    time_o = time_i;
    carry  = 1'b1;
    d      = '0;
    lim    = '0;
    // carry doubles as borrow when counting down
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d   = time_i[i*DIGIT_W +: DIGIT_W];
      lim = digit_limit(i * DIGIT_W);
      if (carry) begin
        if (down_i) begin
          if (d == 4'd0) begin
            time_o[i*DIGIT_W +: DIGIT_W] = lim;
          end else begin
            time_o[i*DIGIT_W +: DIGIT_W] = d - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d >= lim) begin
            time_o[i*DIGIT_W +: DIGIT_W] = 4'd0;
          end else begin
            time_o[i*DIGIT_W +: DIGIT_W] = d + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap_o = carry & ~down_i;
    if (carry && down_i) time_o = ZERO_TIME;
  end

  assign in_zero_o  = (time_i == ZERO_TIME);
  assign out_zero_o = (time_o == ZERO_TIME);

endmodule

// File: rtl/stopwatch_core.sv
// Prescaled BCD stopwatch/countdown with run/pause/clear control and a lap buffer.
// Display is registered: live time or a selected lap entry, one cycle behind.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned LAP_AW    = $clog2(LAP_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_pause_p,
  input  logic              clear_p,
  input  logic              lap_p,
  input  logic              count_down,
  input  logic [23:0]       preset_bcd,
  input  logic              view_lap,
  input  logic [LAP_AW-1:0] lap_idx,
  output logic [23:0]       disp_bcd,
  output logic              running,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic              expired,
  output logic              wrap
);

  localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [LAP_AW:0] LAP_MAX   = (LAP_AW + 1)'(LAP_DEPTH);

  sw_state_e         state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  bcd_time_t         time_q, time_d;
  logic              down_q, down_d;
  logic [LAP_AW:0]   lap_count_q, lap_count_d;
  bcd_time_t         disp_q, disp_d;
  logic              wrap_q, wrap_d;
  bcd_time_t         lap_mem_q [LAP_DEPTH];

  bcd_time_t         step_time;
  logic              step_wrap;
  logic              step_in_zero;
  logic              step_out_zero;
  logic              tick;
  logic              lap_we;
  logic [LAP_AW-1:0] lap_widx;

  bcd_time_step u_step (
    .time_i     (time_q),
    .down_i     (down_q),
    .time_o     (step_time),
    .wrap_o     (step_wrap),
    .in_zero_o  (step_in_zero),
    .out_zero_o (step_out_zero)
  );

  assign tick     = (state_q == StRun) && (presc_q == PRESC_MAX);
  assign lap_widx = lap_count_q[LAP_AW-1:0];
  // Laps store the pre-tick, pre-transition time_q; clear_p cancels any capture.
  assign lap_we   = lap_p && !clear_p && ((state_q == StRun) || (state_q == StPause)) &&
                    (lap_count_q != LAP_MAX);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    time_d      = time_q;
    down_d      = down_q;
    lap_count_d = lap_count_q;
    wrap_d      = 1'b0;
    if (clear_p) begin
      state_d     = StIdle;
      presc_d     = '0;
      lap_count_d = '0;
      down_d      = count_down;
      time_d      = count_down ? clamp_time(preset_bcd) : ZERO_TIME;
    end else begin
      if (state_q == StRun) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        time_d = step_time;
        wrap_d = step_wrap;
      end
      unique case (state_q)
        StIdle: begin
          if (start_pause_p) state_d = (down_q && step_in_zero) ? StExpired : StRun;
        end
        StRun: begin
          if (tick && down_q && step_out_zero) state_d = StExpired;
          else if (start_pause_p)              state_d = StPause;
        end
        StPause: begin
          if (start_pause_p) state_d = StRun;
        end
        StExpired: state_d = StExpired;
        default:   state_d = StIdle;
      endcase
      if (lap_we) lap_count_d = lap_count_q + 1'b1;
    end
  end

  always_comb begin
    disp_d = time_q;
    if (view_lap) begin
      disp_d = ({1'b0, lap_idx} < lap_count_q) ? lap_mem_q[lap_idx] : ZERO_TIME;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      time_q      <= ZERO_TIME;
      down_q      <= 1'b0;
      lap_count_q <= '0;
      disp_q      <= ZERO_TIME;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      time_q      <= time_d;
      down_q      <= down_d;
      lap_count_q <= lap_count_d;
      disp_q      <= disp_d;
      wrap_q      <= wrap_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= ZERO_TIME;
    end else if (lap_we) begin
      lap_mem_q[lap_widx] <= time_q;
    end
  end

  assign disp_bcd  = disp_q;
  assign running   = (state_q == StRun);
  assign expired   = (state_q == StExpired);
  assign lap_count = lap_count_q;
  assign lap_full  = (lap_count_q == LAP_MAX);
  assign wrap      = wrap_q;

endmodule
